// File: rtl/fp32_add_if.sv
// Operand/result bundle for the pipelined FP32 adder.
// master drives operands, slave is the adder.
interface fp32_add_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic [W-1:0] res;

   modport master (
      output in_valid, a, b,
      input  out_valid, res
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, res
   );
endinterface

// File: rtl/fp32_add.sv
// Two-stage FP add, truncating, flush-to-zero.
// Define FP_SPECIALS_EN for Inf/NaN decode and overflow to Inf.
module fp32_add #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic clk,
   input logic rst,
   fp32_add_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 1;
   localparam int LZW = $clog2(SW) + 1;
   localparam int XW  = EXP_W + 2;
   localparam logic [EXP_W-1:0] EMAX = '1;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic [SW-1:0]    ma, mb;
   logic             a_big;
   logic             sl, ss;
   logic [EXP_W-1:0] el, es, d;
   logic [SW-1:0]    ml, ms, msh;

   assign {sa, ea, fa} = bus.a;
   assign {sb, eb, fb} = bus.b;
   assign ma = (ea == '0) ? '0 : {1'b1, fa};
   assign mb = (eb == '0) ? '0 : {1'b1, fb};

   assign a_big = {ea, ma} >= {eb, mb};
   assign sl  = a_big ? sa : sb;
   assign ss  = a_big ? sb : sa;
   assign el  = a_big ? ea : eb;
   assign es  = a_big ? eb : ea;
   assign ml  = a_big ? ma : mb;
   assign ms  = a_big ? mb : ma;
   assign d   = el - es;
   assign msh = (d >= EXP_W'(SW)) ? '0 : (ms >> d);

   logic             v1, s1_sign, s1_sub;
   logic [EXP_W-1:0] s1_exp;
   logic [SW-1:0]    s1_ml, s1_ms;

`ifdef FP_SPECIALS_EN
   localparam logic [W-1:0] QNAN =
      {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
   logic         nan_a, nan_b, inf_a, inf_b;
   logic         spec;
   logic [W-1:0] spec_res;
   logic         s1_spec;
   logic [W-1:0] s1_spec_res;

   assign nan_a = (ea == EMAX) && (fa != '0);
   assign nan_b = (eb == EMAX) && (fb != '0);
   assign inf_a = (ea == EMAX) && (fa == '0);
   assign inf_b = (eb == EMAX) && (fb == '0);
   assign spec  = nan_a | nan_b | inf_a | inf_b;
   assign spec_res =
      (nan_a | nan_b | (inf_a & inf_b & (sa != sb))) ? QNAN :
      inf_a ? bus.a : bus.b;

   always_ff @(posedge clk) begin
      s1_spec     <= spec;
      s1_spec_res <= spec_res;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) v1 <= 1'b0;
      else     v1 <= bus.in_valid;
      s1_sign <= sl;
      s1_sub  <= sl ^ ss;
      s1_exp  <= el;
      s1_ml   <= ml;
      s1_ms   <= msh;
   end

   logic [SW:0]          sum;
   logic [SW-1:0]        diff, man;
   logic [LZW-1:0]       lz;
   logic signed [XW-1:0] e;
   logic [W-1:0]         packed_res;

   assign sum  = {1'b0, s1_ml} + {1'b0, s1_ms};
   assign diff = s1_ml - s1_ms;

   always_comb begin
      lz = '0;
      for (int i = 0; i < SW; i++)
         if (diff[i]) lz = LZW'(SW - 1 - i);
   end

   always_comb begin
      man = '0;
      e   = '0;
      if (!s1_sub) begin
         if (sum[SW]) begin
            man = sum[SW:1];
            e   = {2'b00, s1_exp} + XW'(1);
         end else begin
            man = sum[SW-1:0];
            e   = {2'b00, s1_exp};
         end
      end else begin
         man = diff << lz;
         e   = {2'b00, s1_exp} - XW'(lz);
      end

      if (s1_sub && diff == '0)
         packed_res = '0;
      else if (e <= 0)
         packed_res = {s1_sign, {(W-1){1'b0}}};
      else if (e >= $signed({2'b00, EMAX}))
`ifdef FP_SPECIALS_EN
         packed_res = {s1_sign, EMAX, {MAN_W{1'b0}}};
`else
         packed_res = {s1_sign, EMAX - EXP_W'(1),
                       {MAN_W{1'b1}}};
`endif
      else
         packed_res = {s1_sign, e[EXP_W-1:0],
                       man[MAN_W-1:0]};

`ifdef FP_SPECIALS_EN
      if (s1_spec) packed_res = s1_spec_res;
`endif
   end

   // res holds its value across bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.res       <= '0;
      end else begin
         bus.out_valid <= v1;
         if (v1) bus.res <= packed_res;
      end
   end
endmodule

// File: tb/tb_fp32_add.sv
// Scoreboard bench for fp32_add: directed vectors,
// back-to-back issue, bubbles and reset flush.
module tb_fp32_add;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp32_add_if bus ();

   fp32_add dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag,
                        logic [31:0] got,
                        logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h want %08h",
                  tag, got, want);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         check("rst_ov", {31'b0, bus.out_valid}, 32'h0);
         check("rst_res", bus.res, 32'h0);
         last = '0;
      end else if (bus.out_valid) begin
         if (q.size() == 0) begin
            check("spurious_ov",
                  {31'b0, bus.out_valid}, 32'h0);
         end else begin
            e = q.pop_front();
            check("res", bus.res, e.res);
            check("lat", 32'(cyc), 32'(e.cyc));
            last = e.res;
         end
      end else begin
         check("hold", bus.res, last);
      end
   end

   task automatic drive(logic [31:0] x, logic [31:0] y);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = x;
      bus.b        = y;
   endtask

   task automatic op(logic [31:0] x, logic [31:0] y,
                     logic [31:0] r);
      exp_t e;
      drive(x, y);
      e.res = r;
      e.cyc = cyc + 2;
      q.push_back(e);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.a        = $urandom;
         bus.b        = $urandom;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("drain", 32'(q.size()), 32'h0);
      q.delete();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      op(32'h00000000, 32'h00000000, 32'h00000000);
      op(32'h00000000, 32'h400CCCCD, 32'h400CCCCD);
      op(32'h400CCCCD, 32'h00000000, 32'h400CCCCD);
      op(32'h3F800000, 32'h3F800000, 32'h40000000);
      op(32'h3FC00000, 32'h3FC00000, 32'h40400000);
      op(32'h3F000000, 32'h3F000000, 32'h3F800000);
      op(32'h400CCCCD, 32'h400CCCCD, 32'h408CCCCD);
      op(32'hC0000000, 32'hC0200000, 32'hC0900000);
      op(32'h40400000, 32'hBFC00000, 32'h3FC00000);
      op(32'hBFC00000, 32'h40000000, 32'h3F000000);
      op(32'h3F800000, 32'hBF800000, 32'h00000000);
      op(32'h409AE148, 32'hBF57AE14, 32'h407FD70C);
      idle(1);
      op(32'h80000000, 32'h80000000, 32'h80000000);
      op(32'h80000000, 32'h00000000, 32'h00000000);
      idle(2);
      op(32'h00000001, 32'h3F800000, 32'h3F800000);
      op(32'h00C00000, 32'h80800000, 32'h00000000);
      op(32'h3F800000, 32'h33800000, 32'h3F800000);
      op(32'h3F800000, 32'h34000000, 32'h3F800001);
      op(32'hBF800000, 32'h3F000000, 32'hBF000000);
`ifdef FP_SPECIALS_EN
      op(32'h7F800000, 32'hFF800000, 32'h7FC00000);
      op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      op(32'hFF800000, 32'h3F800000, 32'hFF800000);
      op(32'h3F800000, 32'h7F800001, 32'h7FC00000);
`else
      op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF);
      op(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF);
`endif
      idle(1);
      drain();

      // op1 completes; op2 is in flight when reset hits
      op(32'h3F800000, 32'h3F800000, 32'h40000000);
      drive(32'h40400000, 32'h40400000);
      drive(32'h40800000, 32'h40800000);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(4);
      check("post_rst_q", 32'(q.size()), 32'h0);

      op(32'h3FC00000, 32'h3FC00000, 32'h40400000);
      idle(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/fp32_add.md
Name:
fp32_add

Overview:
- Pipelined IEEE-754 single-precision floating-point adder computing res = a + b.
- Rounding is truncation: bits shifted out during alignment are discarded.
- Subnormals are flushed to zero.
- Used as the FP add datapath unit. Fully pipelined: accepts one operation per cycle, fixed latency 2.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width; the significand is MAN_W+1 bits including the hidden bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b are valid this cycle.
- a  input  1+EXP_W+MAN_W  operand A (sign | exponent | fraction).
- b  input  1+EXP_W+MAN_W  operand B.
- out_valid  output  1  res is valid this cycle.
- res  output  1+EXP_W+MAN_W  sum.

Behaviour:
- Reset: on a clk edge with rst=1, all pipeline valids clear, out_valid=0, res=0.
  - Reset mid-operation discards all in-flight operations; no output appears for them.
- Latency: the operation sampled at edge N (in_valid=1) drives res/out_valid after edge N+2.
  - No backpressure; a new operation may enter every cycle.
  - out_valid is in_valid delayed by 2 cycles.
  - res holds its last value while out_valid=0.
- Stage 1 (register at end):
  - Unpack both operands.
  - Exponent 0 means zero (any fraction ignored, flush-to-zero); otherwise the significand is {1, fraction}.
  - Swap so that operand L has the larger magnitude (compare exponent, then significand).
  - Right-shift S's significand by expL-expS; shifted-out bits are discarded (no guard/round/sticky).
  - A shift of MAN_W+1 or more yields 0.
- Stage 2 (register at end):
  - Same signs: add significands in MAN_W+2 bits. On carry-out, shift right 1 (drop LSB) and increment the exponent.
  - Different signs: compute L-S. A result of 0 gives +0 (0x00000000). Otherwise left-shift to normalise (leading-one detect), shifting zeros in, and decrement the exponent by the shift amount.
  - Result sign = sign of L.
  - Exponent reaching ≤0 flushes to sign-preserved zero.
  - Exponent reaching all-ones: see Optional Feature.
- Zero operands:
  - 0 + x = x exactly.
  - +0 + +0 = +0; -0 + -0 = -0; mixed-sign zeros give +0.
- Pack: res = {sign, exp[EXP_W-1:0], significand[MAN_W-1:0]}.

Optional Feature:
FP_SPECIALS_EN
- Defined:
  - Exponent all-ones inputs are decoded as Inf/NaN.
  - Any NaN input, or Inf + (-Inf), gives canonical qNaN 0x7FC00000 (sign 0, exp all-ones, fraction MSB 1).
  - Inf + finite gives that Inf.
  - Overflow gives ±Inf.
  - Special-case detection happens in stage 1 and travels with the pipeline; latency is unchanged.
- Undefined:
  - No special decoding; exponent all-ones inputs are treated as ordinary normal numbers.
  - Overflow saturates to ±max-finite (exp all-ones-1, fraction all-ones).

Test Plan:
- Zero identity:
  - 00000000+00000000 -> 00000000.
  - 00000000+400CCCCD -> 400CCCCD.
  - 400CCCCD+00000000 -> 400CCCCD.
- Same-sign adds with carry normalisation:
  - 3F800000+3F800000 -> 40000000.
  - 3FC00000+3FC00000 -> 40400000.
  - 3F000000+3F000000 -> 3F800000.
  - 400CCCCD+400CCCCD -> 408CCCCD.
  - C0000000+C0200000 -> C0900000.
- Mixed signs:
  - 40400000+BFC00000 -> 3FC00000.
  - BFC00000+40000000 -> 3F000000.
  - 3F800000+BF800000 -> 00000000 (exact cancel gives +0).
- Truncation with left normalise: 409AE148+BF57AE14 -> 407FD70C; 407FD70B is a failure, since that value comes from keeping guard bits.
- Pipeline/reset:
  - Back-to-back operations on consecutive cycles each emerge exactly 2 cycles later, in order.
  - Asserting rst with 2 operations in flight gives out_valid=0 for the next 2 cycles and res=0.
- FP_SPECIALS_EN:
  - 7F800000+FF800000 -> 7FC00000.
  - 7F7FFFFF+7F7FFFFF -> 7F800000.
  - Without the macro, 7F7FFFFF+7F7FFFFF -> 7F7FFFFF.
